// File: rtl/mem_access.sv
// Memory-stage data access: pass-through for ALU ops, req/ack bus transactions
// for loads and stores, with byte-lane steering and load alignment/extension.
module mem_access #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [3:0]            mem_op_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stall_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [ADDR_WIDTH-1:0] dbus_addr_o,
    output logic [DATA_WIDTH-1:0] dbus_wdata_o,
    output logic [3:0]            dbus_sel_o,
    input  logic                  dbus_ack_i,
    input  logic [DATA_WIDTH-1:0] dbus_rdata_i
);

    localparam int unsigned CNT_W = 8;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    // Transaction context captured on entry to BUSY
    logic [3:0]            r_op;
    logic [1:0]            r_addr_lo;
    logic [4:0]            r_waddr;
    logic                  r_reg_we;
    logic                  r_is_load;
    logic                  r_timed_out;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_bus_err;
    logic                  r_dbus_we;
    logic [ADDR_WIDTH-1:0] r_dbus_addr;
    logic [DATA_WIDTH-1:0] r_dbus_wdata;
    logic [3:0]            r_dbus_sel;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_byte;
    logic                  w_is_half;
    logic                  w_misalign;
    logic [3:0]            w_sel;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_rbyte;
    logic [15:0]           w_rhalf;
    logic [DATA_WIDTH-1:0] w_fmt;
    logic                  w_start;
    logic                  w_timeout;
    logic                  w_tmo_hit;

    // Decode the incoming op
    always_comb begin
        w_is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
        w_is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        w_is_byte  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
        w_is_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
        w_misalign = (w_is_half && mem_addr_i[0])
                   || (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (mem_addr_i[1:0] != 2'b00));
    end

    // Byte-lane enables and replicated store data for the incoming op
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_data_i;
        if (w_is_byte) begin
            w_sel   = 4'(4'b0001 << mem_addr_i[1:0]);
            w_wdata = {4{mem_data_i[7:0]}};
        end else if (w_is_half) begin
            w_sel   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_data_i[15:0]}};
        end
    end

    // Extract and extend the addressed byte/half from read data
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_rbyte = dbus_rdata_i[7:0];
            2'd1:    w_rbyte = dbus_rdata_i[15:8];
            2'd2:    w_rbyte = dbus_rdata_i[23:16];
            default: w_rbyte = dbus_rdata_i[31:24];
        endcase
        w_rhalf = r_addr_lo[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (r_op)
            OP_LB:   w_fmt = {{24{w_rbyte[7]}}, w_rbyte};
            OP_LBU:  w_fmt = {24'd0, w_rbyte};
            OP_LH:   w_fmt = {{16{w_rhalf[15]}}, w_rhalf};
            OP_LHU:  w_fmt = {16'd0, w_rhalf};
            default: w_fmt = dbus_rdata_i;
        endcase
    end

    assign w_tmo_hit = (9'({1'b0, r_cnt}) + 9'd1) >= 9'(TIMEOUT);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and pipeline-facing outputs
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        reg_waddr_o = reg_waddr_i;
        reg_we_o    = reg_we_i;
        reg_wdata_o = reg_wdata_i;
        case (r_state)
            S_IDLE: begin
                if (w_is_load || w_is_store) begin
                    reg_we_o = 1'b0;
                    if (w_misalign) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        w_start = 1'b1;
                        w_next  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall_o  = 1'b1;
                reg_we_o = 1'b0;
                if (dbus_ack_i) begin
                    w_next = S_DONE;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                reg_waddr_o = r_waddr;
                reg_we_o    = r_reg_we && r_is_load && !r_timed_out;
                reg_wdata_o = r_result;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Transaction context, bus registers, timeout counter and load result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op         <= 4'd0;
            r_addr_lo    <= 2'd0;
            r_waddr      <= 5'd0;
            r_reg_we     <= 1'b0;
            r_is_load    <= 1'b0;
            r_timed_out  <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_bus_err    <= 1'b0;
            r_dbus_we    <= 1'b0;
            r_dbus_addr  <= '0;
            r_dbus_wdata <= '0;
            r_dbus_sel   <= 4'd0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_start) begin
                r_op         <= mem_op_i;
                r_addr_lo    <= mem_addr_i[1:0];
                r_waddr      <= reg_waddr_i;
                r_reg_we     <= reg_we_i;
                r_is_load    <= w_is_load;
                r_timed_out  <= 1'b0;
                r_cnt        <= '0;
                r_dbus_we    <= w_is_store;
                r_dbus_addr  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                r_dbus_wdata <= w_wdata;
                r_dbus_sel   <= w_sel;
            end else if (r_state == S_BUSY) begin
                if (dbus_ack_i) begin
                    if (r_is_load) begin
                        r_result <= w_fmt;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        r_timed_out <= 1'b1;
                    end
                end
            end
        end
    end

    assign dbus_req_o   = (r_state == S_BUSY);
    assign dbus_we_o    = r_dbus_we;
    assign dbus_addr_o  = r_dbus_addr;
    assign dbus_wdata_o = r_dbus_wdata;
    assign dbus_sel_o   = r_dbus_sel;
    assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed and randomized transactions against a
// lane/extension model built from plain arithmetic.
module tb_mem_access;

    localparam int unsigned TMO = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic [3:0]  mem_op = '0;
    logic [4:0]  waddr_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        req;
    logic        bwe;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  bsel;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_op_i(mem_op),
        .reg_waddr_i(waddr_i), .reg_we_i(we_i), .reg_wdata_i(wdata_i),
        .reg_waddr_o(waddr_o), .reg_we_o(we_o), .reg_wdata_o(wdata_o),
        .stall_o(stall), .misalign_o(misalign), .bus_err_o(bus_err),
        .dbus_req_o(req), .dbus_we_o(bwe), .dbus_addr_o(baddr),
        .dbus_wdata_o(bwdata), .dbus_sel_o(bsel),
        .dbus_ack_i(ack), .dbus_rdata_i(rdata)
    );

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 1;
        if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (op_size(op) == 1) return 4'(1 << off);
        if (op_size(op) == 2) return (off >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        if (op_size(op) == 1) return (d % 256) * 32'h0101_0101;
        if (op_size(op) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int off = int'(addr % 4);
        if (op_size(op) == 1) begin
            v = (rd >> (8 * off)) % 256;
            if (op == 4'd1 && v >= 128) v = v - 256;
        end else if (op_size(op) == 2) begin
            v = (rd >> (8 * (off / 2) * 2)) % 65536;
            if (op == 4'd2 && v >= 32768) v = v - 65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic go_nop();
        mem_op = 4'd0; mem_we = 1'b0; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0;
        mem_addr = 32'd0; mem_data = 32'd0;
    endtask

    // One full memory transaction; delay >= TMO means the bus never acks.
    task automatic run_mem(input string nm, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] wa, input logic we,
                           input int delay, input logic [31:0] rd);
        logic is_load = (op >= 4'd1 && op <= 4'd5);
        logic to = 1'b1;
        @(posedge clk); #1;
        mem_op = op; mem_addr = addr; mem_data = data; mem_we = !is_load;
        waddr_i = wa; we_i = we; wdata_i = $urandom; ack = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1 || we_o !== 1'b0 || req !== 1'b0) begin
            $display("FAIL %s issue: stall=%b we=%b req=%b, need 1 0 0", nm, stall, we_o, req);
        end else n_pass++;
        for (int k = 0; k < int'(TMO); k++) begin
            @(posedge clk); #1;
            ack = (k == delay);
            rdata = (k == delay) ? rd : $urandom;
            #1;
            n_checks++;
            if (req !== 1'b1 || stall !== 1'b1 || we_o !== 1'b0 || baddr !== (addr & ~32'd3)
                || bsel !== m_sel(op, addr) || bwe !== !is_load) begin
                $display("FAIL %s busy%0d: req=%b stall=%b we=%b addr=%h sel=%b bwe=%b, need 1 1 0 %h %b %b",
                         nm, k, req, stall, we_o, baddr, bsel, bwe, addr & ~32'd3, m_sel(op, addr), !is_load);
            end else n_pass++;
            if (!is_load) begin
                n_checks++;
                if (bwdata !== m_wdata(op, data))
                    $display("FAIL %s wdata: got %h need %h", nm, bwdata, m_wdata(op, data));
                else n_pass++;
            end
            if (k == delay) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        ack = 1'b0; rdata = $urandom;
        #1;
        n_checks++;
        if (req !== 1'b0 || stall !== 1'b0 || bus_err !== to || waddr_o !== wa
            || we_o !== (we && is_load && !to)) begin
            $display("FAIL %s done: req=%b stall=%b err=%b wa=%0d we=%b, need 0 0 %b %0d %b",
                     nm, req, stall, bus_err, waddr_o, we_o, to, wa, we && is_load && !to);
        end else n_pass++;
        if (is_load && !to) begin
            n_checks++;
            if (wdata_o !== m_load(op, addr, rd))
                $display("FAIL %s result: got %h need %h", nm, wdata_o, m_load(op, addr, rd));
            else n_pass++;
        end
        @(posedge clk); #1;
        go_nop();
        #1;
        n_checks++;
        if (bus_err !== 1'b0 || req !== 1'b0 || stall !== 1'b0)
            $display("FAIL %s after: err=%b req=%b stall=%b, need 0 0 0", nm, bus_err, req, stall);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; go_nop();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req, stall, misalign, bus_err, we_o, bwe, bsel, baddr, bwdata, waddr_o, wdata_o} !== '0)
            $display("FAIL reset: outputs req=%b stall=%b mis=%b err=%b we=%b sel=%b addr=%h, need all 0",
                     req, stall, misalign, bus_err, we_o, bsel, baddr);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 10; i++) begin
            logic [3:0] op = (i == 0) ? 4'd0 : ((i % 2 == 1) ? 4'd0 : 4'($urandom_range(9, 15)));
            logic [31:0] d = (i == 0) ? 32'h1234 : $urandom;
            logic [4:0] a = (i == 0) ? 5'd5 : 5'($urandom);
            logic w = (i == 0) ? 1'b1 : 1'($urandom);
            @(posedge clk); #1;
            mem_op = op; wdata_i = d; waddr_i = a; we_i = w; mem_addr = $urandom;
            #1;
            n_checks++;
            if (wdata_o !== d || waddr_o !== a || we_o !== w || stall !== 1'b0 || req !== 1'b0
                || misalign !== 1'b0)
                $display("FAIL passthru%0d: got %h/%0d/%b stall=%b req=%b, need %h/%0d/%b 0 0",
                         i, wdata_o, waddr_o, we_o, stall, req, d, a, w);
            else n_pass++;
        end
        @(posedge clk); #1; go_nop();
    endtask

    task automatic test_directed();
        run_mem("lb_103",  4'd1, 32'h103, 32'h0, 5'd3, 1'b1, 0, 32'h80FF_0011);
        run_mem("lbu_103", 4'd4, 32'h103, 32'h0, 5'd4, 1'b1, 0, 32'h80FF_0011);
        run_mem("sh_0a",   4'd7, 32'h00A, 32'hDEAD_BEEF, 5'd6, 1'b1, 0, 32'h0);
        run_mem("lw_wait", 4'd3, 32'h020, 32'h0, 5'd7, 1'b1, 4, 32'hCAFE_F00D);
        run_mem("lw_tmo",  4'd3, 32'h040, 32'h0, 5'd8, 1'b1, int'(TMO), 32'h0);
        run_mem("ack_last", 4'd2, 32'h0F2, 32'h0, 5'd9, 1'b1, int'(TMO) - 1, 32'h8001_7FFF);
        run_mem("lw_x0",   4'd3, 32'h044, 32'h0, 5'd0, 1'b0, 1, 32'h1111_2222);
    endtask

    task automatic test_misalign();
        logic [3:0]  ops [4]  = '{4'd3, 4'd2, 4'd8, 4'd5};
        logic [31:0] adrs [4] = '{32'h22, 32'h101, 32'h3, 32'h7};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_op = ops[i]; mem_addr = adrs[i]; we_i = 1'b1; waddr_i = 5'd1;
            #1;
            n_checks++;
            if (misalign !== 1'b1 || stall !== 1'b0 || we_o !== 1'b0 || req !== 1'b0)
                $display("FAIL misalign%0d: mis=%b stall=%b we=%b req=%b, need 1 0 0 0",
                         i, misalign, stall, we_o, req);
            else n_pass++;
            @(posedge clk); #1;
            go_nop();
            #1;
            n_checks++;
            if (misalign !== 1'b0 || req !== 1'b0)
                $display("FAIL misalign%0d after: mis=%b req=%b, need 0 0", i, misalign, req);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [3:0] op = 4'($urandom_range(1, 8));
            logic [31:0] a = $urandom & ~32'd3;
            int sz = op_size(op);
            int dl = ($urandom_range(0, 9) == 0) ? int'(TMO) : int'($urandom_range(0, 3));
            if (sz == 1) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2) a = a + 32'(2 * $urandom_range(0, 1));
            run_mem("rand", op, a, $urandom, 5'($urandom), 1'($urandom), dl, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mem_op = 4'd3; mem_addr = 32'h80; we_i = 1'b1; waddr_i = 5'd2;
        @(posedge clk); #1;
        go_nop(); rst = 1'b1;
        #1;
        n_checks++;
        if (req !== 1'b1)
            $display("FAIL rst_mid busy: req=%b need 1", req);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (req !== 1'b0 || stall !== 1'b0 || we_o !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL rst_mid: req=%b stall=%b we=%b err=%b, need 0 0 0 0", req, stall, we_o, bus_err);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        ack = 1'b0;
        n_checks++;
        if (req !== 1'b0 || stall !== 1'b0 || we_o !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL rst_late_ack: req=%b stall=%b we=%b err=%b, need 0 0 0 0",
                     req, stall, we_o, bus_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage data-access unit. It is the responder end of the mem_we/mem_addr/mem_data/mem_op interface produced by the execute stage and registered through exe_mem.
- Non-memory instructions pass straight through to mem_wb.
- Loads and stores become transactions on a word-wide req/ack data bus, with byte-lane steering, load alignment and sign/zero extension.
- While a transaction is outstanding, stall_o holds the pipeline.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data bus width; fixed at 32.
- TIMEOUT, 255, maximum number of BUSY cycles to wait for dbus_ack_i before aborting; legal range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- mem_we_i  in  1  store flag from exe_mem.
- mem_addr_i  in  32  byte address.
- mem_data_i  in  32  store data, right-aligned.
- mem_op_i  in  4  encoding: NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; codes 9..15 are treated as NOP.
- reg_waddr_i  in  5  destination register.
- reg_we_i  in  1  register write enable.
- reg_wdata_i  in  32  ALU result (used for pass-through).
- reg_waddr_o  out  5  to mem_wb and forwarding.
- reg_we_o  out  1  to mem_wb and forwarding.
- reg_wdata_o  out  32  to mem_wb and forwarding.
- stall_o  out  1  holds pc, if_id, id_exe and exe_mem.
- misalign_o  out  1  misaligned-access flag, 1 cycle.
- bus_err_o  out  1  timeout flag, 1 cycle.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write.
- dbus_addr_o  out  32  word address, bits [1:0] always 0.
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_sel_o  out  4  byte enables.
- dbus_ack_i  in  1  bus acknowledge.
- dbus_rdata_i  in  32  read data, valid when ack is high.

Behaviour:
- Reset:
  - State goes to IDLE; timeout counter and result register clear.
  - Next cycle, all outputs are 0 (including dbus_req_o, stall_o, both flags).
  - Reset mid-transaction abandons it. A late ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE, op is NOP:
  - reg_*_o = reg_*_i, combinational.
  - stall_o = 0. Latency 0.
- IDLE, op is a memory op:
  - Misaligned case (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0):
    - misalign_o = 1, reg_we_o = 0, stall_o = 0.
    - No bus request; stay in IDLE.
  - Aligned case:
    - stall_o = 1, reg_we_o = 0 (combinational).
    - Register the bus outputs and go to BUSY.
- Bus outputs:
  - dbus_addr_o = {addr[31:2], 2'b00}.
  - dbus_we_o = 1 for SB/SH/SW.
  - dbus_sel_o:
    - Byte ops: 1 << addr[1:0].
    - Half ops: 0011 when addr[1]=0, 1100 when addr[1]=1.
    - Word ops: 1111.
  - dbus_wdata_o: SB = {4{data[7:0]}}, SH = {2{data[15:0]}}, SW = data.
- BUSY:
  - dbus_req_o = 1, stall_o = 1, reg_we_o = 0.
  - Bus outputs stay stable until ack is sampled.
  - On ack:
    - Loads capture the formatted result: extract the byte/half at addr[1:0]; LB/LH sign-extend, LBU/LHU/LW zero-extend.
    - Drop dbus_req_o on the next cycle; go to DONE.
  - Timeout counter increments each BUSY cycle without ack. When it reaches TIMEOUT:
    - Drop req, pulse bus_err_o for 1 cycle, go to DONE with the write suppressed.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - stall_o = 0.
  - reg_waddr_o = latched waddr.
  - reg_we_o = latched reg_we AND load AND not timed-out.
  - reg_wdata_o = formatted result.
  - Next state is IDLE.
  - Stores: reg_we_o = 0.
- Minimum memory-op latency is 3 cycles: IDLE → BUSY (ack on the first BUSY cycle) → DONE.
- dbus_ack_i is ignored in IDLE and DONE.
- Loads to x0 still issue the bus read; the write is suppressed only via the latched reg_we.

Test Plan:
- Pass-through: op=NOP, reg_wdata_i=0x1234, waddr=5, we=1 → same-cycle reg_wdata_o=0x1234, stall_o=0, dbus_req_o never 1.
- LB sign/zero:
  - LB at addr 0x103, ack on the first BUSY cycle with rdata 0x80FF_0011 → dbus_addr_o=0x100, sel=1000, DONE reg_wdata_o=0xFFFF_FF80.
  - Same access as LBU → 0x0000_0080.
  - Total stall 2 cycles.
- SH at addr 0x0A, data 0xDEAD_BEEF → dbus_we_o=1, sel=1100, wdata=0xBEEF_BEEF, reg_we_o=0 in DONE.
- Wait states: LW at 0x20, ack delayed 4 cycles → req and address held for 4+1 BUSY cycles, stall_o high throughout, result = rdata.
- Timeout: TIMEOUT=3, no ack → req high for 3 cycles, bus_err_o pulses once, reg_we_o=0, back to IDLE.
- Misaligned and reset:
  - LW at 0x22 → misalign_o=1 for 1 cycle, no req.
  - rst_i asserted in BUSY → next cycle req=0, stall_o=0; a following ack is ignored.
